// File: rtl/vid_pattern_gen_if.sv
// Video output bundle: pixel data qualified by DE, with HS/VS sync, driven by the pattern source.
interface vid_pattern_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  de;
    logic                  hs;
    logic                  vs;

    modport master (output data, de, hs, vs);
    modport slave  (input  data, de, hs, vs);
endinterface

// File: rtl/vid_pattern_gen.sv
// Free-running DE/HS/VS timing generator with selectable 8-bit test patterns.
// Runs whole frames only: en_i is acted upon at frame boundaries.
module vid_pattern_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic [1:0]               pattern_i,
    vid_pattern_gen_if.master        vid_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic [7:0]               frcnt_o
);
    localparam int unsigned HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned Lanes = DATA_WIDTH / 8;

    localparam logic [11:0] HtLast  = 12'(HT - 1);
    localparam logic [11:0] VtLast  = 12'(VT - 1);
    localparam logic [11:0] HActive = 12'(H_ACTIVE);
    localparam logic [11:0] VActive = 12'(V_ACTIVE);
    localparam logic [11:0] HsStart = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HsEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VsStart = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VsEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        run, line_end, frame_end, frame_start;

    assign run         = (state_q == StRun);
    assign line_end    = (hcnt_q == HtLast);
    assign frame_end   = line_end && (vcnt_q == VtLast);
    assign frame_start = run && (hcnt_q == '0) && (vcnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        unique case (state_q)
            StIdle: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en_i) state_d = StRun;
            end
            StRun: begin
                if (line_end) begin
                    hcnt_d = '0;
                    if (frame_end) begin
                        vcnt_d = '0;
                        if (!en_i) state_d = StIdle;
                    end else begin
                        vcnt_d = vcnt_q + 12'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 12'd1;
                end
            end
        endcase
    end

    logic [1:0]            pat_q, pat_sel;
    logic [7:0]            x, y, pix;
    logic                  de_d, hs_d, vs_d;
    logic                  de_q, hs_q, vs_q, busy_q, done_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [7:0]            frcnt_q, frcnt_d;

    // The first pixel of a frame uses the pattern being latched on that same cycle.
    always_comb begin
        pat_sel = frame_start ? pattern_i : pat_q;
        x       = hcnt_q[7:0];
        y       = vcnt_q[7:0];
        pix     = x;
        unique case (pat_sel)
            2'd0: pix = x;
            2'd1: pix = y;
            2'd2: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            2'd3: pix = x + frcnt_q;
        endcase
        de_d    = run && (hcnt_q < HActive) && (vcnt_q < VActive);
        hs_d    = run && (hcnt_q >= HsStart) && (hcnt_q < HsEnd);
        vs_d    = run && (vcnt_q >= VsStart) && (vcnt_q < VsEnd);
        data_d  = de_d ? {Lanes{pix}} : '0;
        frcnt_d = (run && frame_end) ? frcnt_q + 8'd1 : frcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            frcnt_q <= '0;
        end else begin
            if (frame_start) pat_q <= pattern_i;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            busy_q  <= run;
            done_q  <= run && frame_end;
            data_q  <= data_d;
            frcnt_q <= frcnt_d;
        end
    end

    assign vid_o.data   = data_q;
    assign vid_o.de     = de_q;
    assign vid_o.hs     = hs_q;
    assign vid_o.vs     = vs_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign frcnt_o      = frcnt_q;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen on a 14x7 timing grid with a 16-bit (two-lane) pixel bus.
module tb_vid_pattern_gen;
    localparam int unsigned DW = 16;
    localparam int HFP = 2;
    localparam int HSYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_i;
    logic [1:0] pattern_i;
    logic       busy_o, frame_done_o;
    logic [7:0] frcnt_o;

    vid_pattern_gen_if #(.DATA_WIDTH(DW)) vid ();

    vid_pattern_gen #(
        .DATA_WIDTH(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .pattern_i    (pattern_i),
        .vid_o        (vid),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frcnt_o      (frcnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Frame monitor state, written only by the monitor process.
    logic [DW-1:0] cur_fb [4][8];
    logic [DW-1:0] fb [8][4][8];
    int frames, cur_len, cur_de, cur_hs, cur_vs;
    int last_len, last_de, last_hs, last_vs, last_period, since_done;
    int line, col, gap_cnt, hs_run, gap_n;
    int idle_act, bad_idle, bad_rep, bad_gap, bad_hs;
    bit prev_de, prev_hs, gap_on;

    initial begin
        frames = 0; idle_act = 0; bad_idle = 0; bad_rep = 0; bad_gap = 0; bad_hs = 0;
        gap_n = 0; last_len = 0; last_de = 0; last_hs = 0; last_vs = 0; last_period = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                frames = 0; cur_len = 0; cur_de = 0; cur_hs = 0; cur_vs = 0; since_done = 0;
                line = 0; col = 0; hs_run = 0; prev_de = 0; prev_hs = 0; gap_on = 0;
            end else begin
                since_done++;
                if (busy_o) cur_len++;
                if (!busy_o && (vid.de || vid.hs || vid.vs)) idle_act++;
                if (!vid.de && vid.data != '0) bad_idle++;
                if (vid.data[15:8] != vid.data[7:0]) bad_rep++;
                if (vid.de) begin
                    if (line < 4 && col < 8) cur_fb[line][col] = vid.data;
                    col++;
                    cur_de++;
                end
                if (prev_de && !vid.de) begin
                    line++; col = 0; gap_cnt = 0; gap_on = 1;
                end
                if (gap_on) begin
                    if (vid.hs) begin
                        gap_n++;
                        if (gap_cnt != HFP) bad_gap++;
                        gap_on = 0;
                    end else gap_cnt++;
                end
                if (vid.hs) begin cur_hs++; hs_run++; end
                if (prev_hs && !vid.hs) begin
                    if (hs_run != HSYNC) bad_hs++;
                    hs_run = 0;
                end
                if (vid.vs) cur_vs++;
                prev_de = vid.de;
                prev_hs = vid.hs;
                if (frame_done_o) begin
                    if (frames < 8) fb[frames] = cur_fb;
                    last_len = cur_len; last_de = cur_de; last_hs = cur_hs; last_vs = cur_vs;
                    last_period = since_done;
                    since_done = 0; frames++;
                    cur_len = 0; cur_de = 0; cur_hs = 0; cur_vs = 0; line = 0; col = 0;
                end
            end
        end
    end

    task automatic wait_frames(input int n, input int limit);
        for (int i = 0; i < limit && frames < n; i++) @(negedge clk);
        chk($sformatf("wait_frames_%0d", n), int'(frames >= n), 1);
    endtask

    task automatic wait_pos(input int f, input int pos);
        for (int i = 0; i < 500 && !(frames > f || (frames == f && cur_len >= pos)); i++)
            @(negedge clk);
        chk($sformatf("wait_pos_%0d", f), int'(frames == f && cur_len >= pos), 1);
    endtask

    typedef struct {
        int f;
        int y;
        int x;
        int exp;
    } vec_t;
    vec_t vecs [13];

    initial begin
        // frame, line, pixel, expected byte
        vecs[0]  = '{0, 0, 0, 8'h00};  vecs[1]  = '{0, 2, 5, 8'h05};  vecs[2] = '{0, 3, 7, 8'h07};
        vecs[3]  = '{1, 1, 3, 8'h03};  vecs[4]  = '{1, 3, 6, 8'h06};
        vecs[5]  = '{2, 0, 7, 8'h00};  vecs[6]  = '{2, 1, 0, 8'h01};  vecs[7] = '{2, 3, 4, 8'h03};
        vecs[8]  = '{3, 0, 0, 8'h00};  vecs[9]  = '{3, 3, 7, 8'h00};
        vecs[10] = '{4, 0, 0, 8'h04};  vecs[11] = '{4, 2, 7, 8'h0B};
        vecs[12] = '{5, 1, 2, 8'h07};

        rst_n = 1'b0; en_i = 1'b1; pattern_i = 2'd0;
        repeat (4) @(negedge clk);
        chk("rst_de", int'(vid.de), 0);
        chk("rst_hs", int'(vid.hs), 0);
        chk("rst_vs", int'(vid.vs), 0);
        chk("rst_data", int'(vid.data), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(frame_done_o), 0);
        chk("rst_frcnt", int'(frcnt_o), 0);
        rst_n = 1'b1;

        // Pattern changes mid-frame only take effect from the next frame.
        wait_pos(1, 40);
        chk("f0_len", last_len, 98);
        chk("f0_de", last_de, 32);
        chk("f0_hs", last_hs, 14);
        chk("f0_vs", last_vs, 14);
        chk("f0_frcnt", int'(frcnt_o), 1);
        pattern_i = 2'd1;
        wait_pos(2, 40);
        chk("f1_period", last_period, 98);
        chk("f1_frcnt", int'(frcnt_o), 2);
        pattern_i = 2'd2;
        wait_pos(3, 40);
        pattern_i = 2'd3;
        wait_pos(5, 30);
        en_i = 1'b0;
        wait_frames(6, 300);
        chk("f5_len", last_len, 98);
        chk("f5_de", last_de, 32);
        chk("f5_frcnt", int'(frcnt_o), 6);
        repeat (2) @(negedge clk);
        chk("stop_busy", int'(busy_o), 0);
        repeat (200) @(negedge clk);
        chk("stop_idle_act", idle_act, 0);
        chk("stop_frames", frames, 6);

        for (int i = 0; i < 13; i++)
            chk($sformatf("pix_f%0d_y%0d_x%0d", vecs[i].f, vecs[i].y, vecs[i].x),
                int'(fb[vecs[i].f][vecs[i].y][vecs[i].x]), vecs[i].exp * 257);

        // Asynchronous reset in the middle of a running frame.
        en_i = 1'b1;
        for (int i = 0; i < 300 && !(busy_o && cur_len >= 20); i++) @(negedge clk);
        chk("mid_running", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_de", int'(vid.de), 0);
        chk("mid_rst_data", int'(vid.data), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_frcnt", int'(frcnt_o), 0);
        en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", int'(busy_o), 0);

        // Long run: frame counter wraps.
        en_i = 1'b1; pattern_i = 2'd0;
        wait_frames(255, 255 * 98 + 200);
        chk("frcnt_255", int'(frcnt_o), 255);
        wait_frames(256, 400);
        chk("frcnt_wrap", int'(frcnt_o), 0);
        chk("wrap_period", last_period, 98);
        chk("idle_data_zero", bad_idle, 0);
        chk("lane_replication", bad_rep, 0);
        chk("hs_gap_after_de", bad_gap, 0);
        chk("hs_width", bad_hs, 0);
        chk("gaps_seen", int'(gap_n > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
